// File: rtl/keypad_scan_ctrl.sv
// Column-scan, debounce and key-acceptance sequencer for a 4x4 keypad.
// Emits one key_valid pulse per physical press; key_held tracks the press until its release is debounced.
module keypad_scan_ctrl #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [3:0] row_in,
    input  logic [3:0] key_value,
    output logic [3:0] col_shift_reg,
    output logic [3:0] row_sync,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [BW-1:0]   deb_q, deb_d;
    logic [3:0]      snap_q, snap_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;
    logic [3:0]      meta_q;
    logic [3:0]      sync_q;

    function automatic logic [3:0] rotate_right(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 4'd0;
            sync_q <= 4'd0;
        end else begin
            meta_q <= row_in;
            sync_q <= meta_q;
        end
    end

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SCAN;
            col_q   <= 4'b1000;
            dwell_q <= '0;
            deb_q   <= '0;
            snap_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            snap_q  <= snap_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        snap_d  = snap_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;

        case (state_q)
            ST_SCAN: begin
                if (scan_en) begin
                    if (dwell_q == DWELL_LAST) begin
                        // Only a single active row is a candidate; zero or multi-hot keeps rotating.
                        if (is_onehot(sync_q)) begin
                            snap_d  = sync_q;
                            deb_d   = '0;
                            dwell_d = '0;
                            state_d = ST_DEBOUNCE;
                        end else begin
                            col_d   = rotate_right(col_q);
                            dwell_d = '0;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (sync_q == snap_q) begin
                    if (deb_q == DEB_LAST) begin
                        code_d  = key_value;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    dwell_d = '0;
                    state_d = ST_SCAN;
                end
            end

            ST_HOLD: begin
                if (sync_q == 4'd0) begin
                    deb_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (sync_q == 4'd0) begin
                    if (deb_q == DEB_LAST) begin
                        // Advance so the just-released column is not rescanned first.
                        held_d  = 1'b0;
                        dwell_d = '0;
                        col_d   = rotate_right(col_q);
                        state_d = ST_SCAN;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    assign col_shift_reg = col_q;
    assign row_sync      = sync_q;
    assign key_code      = code_q;
    assign key_valid     = valid_q;
    assign key_held      = held_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencing controller for the 4x4 keypad decoder.
- Drives the one-hot column strobe and synchronizes the raw row lines.
- Debounces presses, latches the decoder's key_value, and emits exactly one key_valid pulse per physical press.
- Sits between the keypad pins and the row decoder; feeds the operand-entry logic of the Booth multiplier.

Parameters:
SCAN_DWELL, 4, cycles each column stays driven (min 3; covers 2-FF sync latency).
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a press or a release (min 1).

Ports:
slow_clk  input  1  scan clock, rising edge.
rst  input  1  asynchronous, active-low reset.
scan_en  input  1  when high, SCAN state rotates columns and samples rows.
row_in  input  4  raw keypad rows, asynchronous; bit3 = top row.
key_value  input  4  decoder output for (col_shift_reg, row_sync).
col_shift_reg  output  4  one-hot column drive, to keypad and decoder.
row_sync  output  4  row_in after 2-FF synchronizer, to decoder.
key_code  output  4  last accepted key value.
key_valid  output  1  one-cycle pulse when key_code updates.
key_held  output  1  high from acceptance until release is debounced.

Behaviour:
- Reset (rst low, async):
  - sync FFs, row_sync = 0; col_shift_reg = 4'b1000.
  - key_code = 0, key_valid = 0, key_held = 0.
  - state = SCAN; dwell_cnt = 0, deb_cnt = 0.
  - Reset mid-press: full return to these values; no pulse is emitted.
- Synchronizer: row_sync is row_in delayed 2 cycles. All decisions use row_sync only.
- States: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN:
  - scan_en = 0: col_shift_reg and dwell_cnt frozen; no sampling.
  - scan_en = 1: dwell_cnt increments each cycle.
  - At dwell_cnt == SCAN_DWELL-1:
    - If row_sync is one-hot: snapshot it into row_snap, go DEBOUNCE, deb_cnt = 0, column held.
    - Otherwise (zero or multi-hot): rotate right (1000->0100->0010->0001->1000) and set dwell_cnt = 0.
  - Multi-key presses are never accepted.
- DEBOUNCE:
  - Column frozen; scan_en ignored.
  - Each cycle, row_sync == row_snap increments deb_cnt. Any mismatch returns to SCAN on the same column with dwell_cnt = 0 and no pulse.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 with a match:
    - next edge: key_code <= key_value, key_valid = 1 for exactly one cycle, key_held = 1, go HOLD.
- HOLD:
  - row_sync != 0: stay.
  - row_sync == 0: go RELEASE, deb_cnt = 0.
  - Changing to a different key while held produces no new pulse.
- RELEASE:
  - row_sync == 0 increments deb_cnt. Reaching DEBOUNCE_CYCLES-1 -> SCAN, key_held = 0, dwell_cnt = 0.
  - On re-entering SCAN the column advances one position, so rotation resumes at the next column.
  - row_sync != 0 returns to HOLD (bounce); no pulse.
- key_code keeps its value until the next acceptance.
- key_valid is never high on two consecutive cycles.
- Latency: row_in stable through the sample point -> key_valid = 2 (sync) + residual dwell + DEBOUNCE_CYCLES + 1 cycles.
- col_shift_reg is always exactly one-hot.
- Counters are sized to clog2 of their parameter and never wrap inside a state.

Test Plan:
- Reset, scan_en = 1, no keys, 20 cycles -> col_shift_reg sequence 1000,0100,0010,0001,1000, each held 4 cycles; key_valid never asserts.
- Hold row_in = 4'b0100 only while col_shift_reg = 0100 (key "6"), bench decoder model -> exactly one key_valid pulse, key_code = 4'b0110, key_held = 1; after release + 4 zero cycles, key_held = 0 and scanning resumes at column 0010.
- Bounce: row_in toggles 0100/0000 every cycle during DEBOUNCE -> no key_valid; controller returns to SCAN on column 0100.
- Release bounce: in HOLD, drop rows for 2 cycles then reassert, then release cleanly -> exactly one pulse total; key_held stays 1 until the clean release.
- Two rows simultaneously (row_in = 4'b1100) -> never leaves SCAN; no pulse; rotation continues.
- scan_en deasserted mid-dwell -> column and dwell frozen. Assert rst low during DEBOUNCE -> all outputs at reset values immediately, col_shift_reg = 1000, no pulse after rst releases.
